// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - running-LED mode/rate sequencer with prescaled step timebase
//
// Purpose : Prescales CLK into a base tick, divides it by 1/2/4/8 according to
//           the rate setting, and on each resulting step advances the LED
//           pattern of the current mode (RIGHT, LEFT, BOUNCE, BLINK).
// Ports   : CLK, RSTn (async, active-low)
//           Key_Mode/Key_Speed/Key_Pause - single-cycle key pulses
//           LED_Out    - registered LED drive, 1 = lit
//           Mode_Out   - current mode (0 RIGHT, 1 LEFT, 2 BOUNCE, 3 BLINK)
//           Speed_Out  - current rate setting (step every T_BASE << Speed)
//           Step_Out   - high in the cycle LED_Out shows a new step value
//           Paused_Out - high while paused
// Options : define LED_CTRL_PAUSE_EN to build the pause register driven by
//           Key_Pause; otherwise Key_Pause is ignored and Paused_Out is 0.
module led_pattern_ctrl #(
  parameter int               CNT_W  = 23,
  parameter logic [CNT_W-1:0] T_BASE = 23'd5_000_000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Key_Mode,
  input  logic       Key_Speed,
  input  logic       Key_Pause,
  output logic [7:0] LED_Out,
  output logic [1:0] Mode_Out,
  output logic [1:0] Speed_Out,
  output logic       Step_Out,
  output logic       Paused_Out
);

  typedef enum logic [1:0] {
    MODE_RIGHT  = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  localparam logic [CNT_W-1:0] LP_CNT_TOP = T_BASE - CNT_W'(1);

  mode_t            r_mode, w_mode_nxt;
  logic [1:0]       r_speed, w_speed_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [2:0]       r_div, w_div_nxt, w_div_top;
  logic             r_dir, w_dir_nxt;
  logic [7:0]       r_led, w_led_nxt, w_pat, w_init;
  logic             r_step, w_step_nxt;
  logic             w_pat_dir, w_left;
  logic             w_run, w_tick, w_key, w_step;

`ifdef LED_CTRL_PAUSE_EN
  logic r_paused;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)          r_paused <= 1'b0;
    else if (Key_Pause) r_paused <= ~r_paused;
  end

  // The toggle cycle itself also freezes the timebase, so pausing at Count=N
  // holds N and resuming continues from N.
  assign w_run      = ~r_paused & ~Key_Pause;
  assign Paused_Out = r_paused;
`else
  logic w_unused_pause;
  assign w_unused_pause = Key_Pause;
  assign w_run          = 1'b1;
  assign Paused_Out     = 1'b0;
`endif

  // Divider terminal value is (2^Speed)-1.
  always_comb begin
    case (r_speed)
      2'd0:    w_div_top = 3'd0;
      2'd1:    w_div_top = 3'd1;
      2'd2:    w_div_top = 3'd3;
      default: w_div_top = 3'd7;
    endcase
  end

  assign w_tick = (r_count == LP_CNT_TOP);
  assign w_key  = Key_Mode | Key_Speed;
  // Key actions take priority over a coincident step.
  assign w_step = w_tick & (r_div == w_div_top) & w_run & ~w_key;

  // Next pattern value; degenerate values fall back to the mode's init value.
  always_comb begin
    w_pat     = r_led;
    w_pat_dir = r_dir;
    w_left    = 1'b0;
    case (r_mode)
      MODE_RIGHT: w_pat = (r_led == 8'h00) ? 8'h01 : {r_led[0], r_led[7:1]};
      MODE_LEFT:  w_pat = (r_led == 8'h00) ? 8'h80 : {r_led[6:0], r_led[7]};
      MODE_BOUNCE: begin
        if (!$onehot(r_led)) begin
          w_pat     = 8'h01;
          w_pat_dir = 1'b0;
        end else begin
          // An end bit forces the direction so a lit end is never repeated.
          w_left    = r_led[0] | (~r_dir & ~r_led[7]);
          w_pat     = w_left ? {r_led[6:0], 1'b0} : {1'b0, r_led[7:1]};
          w_pat_dir = w_left ? w_pat[7] : ~w_pat[0];
        end
      end
      default:    w_pat = (r_led == 8'h00) ? 8'h55 : ~r_led;
    endcase
  end

  always_comb begin
    w_mode_nxt  = r_mode;
    w_speed_nxt = r_speed;
    w_count_nxt = r_count;
    w_div_nxt   = r_div;
    w_dir_nxt   = r_dir;
    w_led_nxt   = r_led;
    w_step_nxt  = 1'b0;
    w_init      = 8'h01;
    if (w_key) begin
      w_count_nxt = '0;
      w_div_nxt   = '0;
      if (Key_Mode) begin
        w_mode_nxt = mode_t'(r_mode + 2'd1);
        case (w_mode_nxt)
          MODE_LEFT:  w_init = 8'h80;
          MODE_BLINK: w_init = 8'h55;
          default:    w_init = 8'h01;
        endcase
        w_led_nxt = w_init;
        w_dir_nxt = 1'b0;
      end
      if (Key_Speed) w_speed_nxt = r_speed + 2'd1;
    end else if (w_run) begin
      if (w_tick) begin
        w_count_nxt = '0;
        w_div_nxt   = r_div + 3'd1;
      end else begin
        w_count_nxt = r_count + CNT_W'(1);
      end
      if (w_step) begin
        w_div_nxt  = '0;
        w_led_nxt  = w_pat;
        w_dir_nxt  = w_pat_dir;
        w_step_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_mode  <= MODE_RIGHT;
      r_speed <= 2'd0;
      r_count <= '0;
      r_div   <= 3'd0;
      r_dir   <= 1'b0;
      r_led   <= 8'h01;
      r_step  <= 1'b0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_speed <= w_speed_nxt;
      r_count <= w_count_nxt;
      r_div   <= w_div_nxt;
      r_dir   <= w_dir_nxt;
      r_led   <= w_led_nxt;
      r_step  <= w_step_nxt;
    end
  end

  assign LED_Out   = r_led;
  assign Mode_Out  = r_mode;
  assign Speed_Out = r_speed;
  assign Step_Out  = r_step;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - self-checking bench for led_pattern_ctrl (T_BASE=4)
module tb_led_pattern_ctrl;

  localparam int TB = 4;
`ifdef LED_CTRL_PAUSE_EN
  localparam bit PAUSE_BUILD = 1'b1;
`else
  localparam bit PAUSE_BUILD = 1'b0;
`endif

  logic       CLK, RSTn, Key_Mode, Key_Speed, Key_Pause;
  logic [7:0] LED_Out;
  logic [1:0] Mode_Out, Speed_Out;
  logic       Step_Out, Paused_Out;

  led_pattern_ctrl #(.CNT_W(23), .T_BASE(23'd4)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .Key_Mode(Key_Mode), .Key_Speed(Key_Speed), .Key_Pause(Key_Pause),
    .LED_Out(LED_Out), .Mode_Out(Mode_Out), .Speed_Out(Speed_Out),
    .Step_Out(Step_Out), .Paused_Out(Paused_Out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: mode, rate, steps taken since the pattern was (re)loaded,
  // and cycles elapsed since the timebase was last cleared.
  int         m_mode, m_speed, m_n, m_t;
  bit         m_bad, m_paused, m_step;
  logic [7:0] m_bad_val;

  function automatic logic [7:0] pat(input int mode, input int n);
    logic [7:0] one;
    int p;
    one = 8'h01;
    case (mode)
      0: return one << ((8 - n % 8) % 8);
      1: return one << ((7 + n) % 8);
      2: begin
        p = n % 14;
        return one << ((p <= 7) ? p : 14 - p);
      end
      default: return (n % 2 == 1) ? 8'hAA : 8'h55;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_speed = 0; m_n = 0; m_t = 0;
    m_bad = 0; m_paused = 0; m_step = 0; m_bad_val = 8'h00;
  endtask

  task automatic check_all();
    chk("led",    LED_Out, m_bad ? m_bad_val : pat(m_mode, m_n));
    chk("mode",   {6'b0, Mode_Out},   8'(m_mode));
    chk("speed",  {6'b0, Speed_Out},  8'(m_speed));
    chk("step",   {7'b0, Step_Out},   {7'b0, m_step});
    chk("paused", {7'b0, Paused_Out}, {7'b0, m_paused});
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_led"},    LED_Out, 8'h01);
    chk({tag, "_mode"},   {6'b0, Mode_Out}, 8'h00);
    chk({tag, "_speed"},  {6'b0, Speed_Out}, 8'h00);
    chk({tag, "_step"},   {7'b0, Step_Out}, 8'h00);
    chk({tag, "_paused"}, {7'b0, Paused_Out}, 8'h00);
  endtask

  // One clock cycle with the given key pulses; entered and left at negedge.
  task automatic step_cycle(input bit km, input bit ks, input bit kp);
    Key_Mode = km; Key_Speed = ks; Key_Pause = kp;
    @(posedge CLK);
    m_step = 0;
    if (km || ks) begin
      if (km) begin m_mode = (m_mode + 1) % 4; m_n = 0; m_bad = 0; end
      if (ks) m_speed = (m_speed + 1) % 4;
      m_t = 0;
    end else if (!(PAUSE_BUILD && (m_paused || kp))) begin
      m_t++;
      if (m_t == (TB << m_speed)) begin
        m_t = 0;
        m_step = 1;
        if (m_bad) begin m_n = 0; m_bad = 0; end
        else m_n++;
      end
    end
    if (PAUSE_BUILD && kp) m_paused = !m_paused;
    #1;
    check_all();
    @(negedge CLK);
    Key_Mode = 0; Key_Speed = 0; Key_Pause = 0;
  endtask

  // Backdoor corruption of the LED register between clock edges.
  task automatic poke(input logic [7:0] v);
    force dut.r_led = v;
    #1;
    release dut.r_led;
    m_bad = 1;
    m_bad_val = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    RSTn = 0; Key_Mode = 0; Key_Speed = 0; Key_Pause = 0;
    model_reset();

    // Keys during reset are ignored
    repeat (3) begin
      @(negedge CLK);
      Key_Mode = 1; Key_Speed = 1; Key_Pause = 1;
    end
    @(negedge CLK);
    Key_Mode = 0; Key_Speed = 0; Key_Pause = 0;
    check_reset("rst");
    RSTn = 1;

    // Free running RIGHT at speed 0
    repeat (3) step_cycle(0, 0, 0);
    step_cycle(0, 0, 0);
    chk("t1_first_led", LED_Out, 8'h80);
    chk("t1_first_step", {7'b0, Step_Out}, 8'h01);
    repeat (4) step_cycle(0, 0, 0);
    chk("t1_second_led", LED_Out, 8'h40);
    repeat (24) step_cycle(0, 0, 0);
    chk("t1_wrap_led", LED_Out, 8'h01);

    // Mode key in the same cycle as a pending step
    repeat (3) step_cycle(0, 0, 0);
    step_cycle(1, 0, 0);
    chk("t4_mode", {6'b0, Mode_Out}, 8'h01);
    chk("t4_led", LED_Out, 8'h80);
    chk("t4_nostep", {7'b0, Step_Out}, 8'h00);
    repeat (4) step_cycle(0, 0, 0);
    chk("t4_next", LED_Out, 8'h01);

    // BOUNCE sequence
    step_cycle(1, 0, 0);
    chk("t3_init", LED_Out, 8'h01);
    repeat (28) step_cycle(0, 0, 0);
    chk("t3_top", LED_Out, 8'h80);
    repeat (4) step_cycle(0, 0, 0);
    chk("t3_turn", LED_Out, 8'h40);
    repeat (24) step_cycle(0, 0, 0);
    chk("t3_bottom", LED_Out, 8'h01);
    repeat (4) step_cycle(0, 0, 0);
    chk("t3_up", LED_Out, 8'h02);

    // Rate setting and wrap
    step_cycle(0, 1, 0);
    step_cycle(0, 1, 0);
    chk("t2_speed2", {6'b0, Speed_Out}, 8'h02);
    repeat (40) step_cycle(0, 0, 0);
    step_cycle(0, 1, 0);
    step_cycle(0, 1, 0);
    chk("t2_wrap", {6'b0, Speed_Out}, 8'h00);

    // BLINK with corruption recovery
    step_cycle(1, 0, 0);
    chk("t5_init", LED_Out, 8'h55);
    repeat (8) step_cycle(0, 0, 0);
    poke(8'h00);
    repeat (4) step_cycle(0, 0, 0);
    chk("t5_recover", LED_Out, 8'h55);
    repeat (4) step_cycle(0, 0, 0);
    chk("t5_alt", LED_Out, 8'hAA);

    // BOUNCE recovery from a non-one-hot value
    repeat (3) step_cycle(1, 0, 0);
    repeat (4) step_cycle(0, 0, 0);
    poke(8'h81);
    repeat (4) step_cycle(0, 0, 0);
    chk("bounce_recover", LED_Out, 8'h01);

    // Mode and rate keys together
    step_cycle(1, 1, 0);
    chk("both_mode", {6'b0, Mode_Out}, 8'h03);
    chk("both_speed", {6'b0, Speed_Out}, 8'h01);

    // Pause at Count=2
    step_cycle(1, 0, 0);
    repeat (3) step_cycle(0, 1, 0);
    repeat (2) step_cycle(0, 0, 0);
    step_cycle(0, 0, 1);
`ifdef LED_CTRL_PAUSE_EN
    chk("t6_paused", {7'b0, Paused_Out}, 8'h01);
    repeat (20) step_cycle(0, 0, 0);
    chk("t6_frozen", LED_Out, 8'h01);
    step_cycle(0, 0, 1);
    step_cycle(0, 0, 0);
    step_cycle(0, 0, 0);
    chk("t6_resume_step", {7'b0, Step_Out}, 8'h01);
    chk("t6_resume_led", LED_Out, 8'h80);
`else
    chk("t6_nopause", {7'b0, Paused_Out}, 8'h00);
    step_cycle(0, 0, 0);
    chk("t6_step", {7'b0, Step_Out}, 8'h01);
    chk("t6_led", LED_Out, 8'h80);
`endif

    // Randomized run against the model
    for (int i = 0; i < 1500; i++) begin
      bit km, ks, kp;
      km = ($urandom_range(0, 39) == 0);
      ks = ($urandom_range(0, 39) == 0);
      kp = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) begin
        v = 8'h00;
        if (m_mode == 2 && $urandom_range(0, 1) == 1) begin
          do v = 8'($urandom_range(1, 255)); while ($countones(v) == 1);
        end
        poke(v);
      end
      step_cycle(km, ks, kp);
    end

    // Asynchronous reset mid-operation
    #2;
    RSTn = 0;
    #1;
    check_reset("async_rst");
    model_reset();
    @(negedge CLK);
    RSTn = 1;
    repeat (8) step_cycle(0, 0, 0);
    chk("post_rst_led", LED_Out, 8'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
